sn_stream_decoder: RTL
======================

SN_STREAM_DECODER -- requirements
Module: sn_stream_decoder

Interface
REQ-001 Parameter MIN_WIN_LOG2, default 3, log2 of the shortest window; the widths below are for the default.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-high despite the name; 1 = reset.
REQ-004 en  in  1  1 = run windows; 0 = hold in IDLE.
REQ-005 clear  in  1  synchronous abort: discard the partial window and any pending result.
REQ-006 sn_bit  in  1  stochastic bitstream bit.
REQ-007 sn_valid  in  1  qualifies sn_bit; a bit is counted only when sn_valid=1.
REQ-008 win_sel  in  2  window length N = 2^(MIN_WIN_LOG2+win_sel), giving 8/16/32/64.
REQ-009 out_ready  in  1  consumer accepts the result.
REQ-010 out_valid  out  1  result registers hold an unconsumed result.
REQ-011 ones_cnt  out  7  count of 1s in the window (0..64).
REQ-012 bipolar  out  8  signed two's complement, 2*ones_cnt - N.
REQ-013 unipolar_q8  out  8  ones_cnt*256/N, saturated to 255.
REQ-014 res_sel  out  2  win_sel value used for the held result.
REQ-015 lost  out  1  sticky flag; 1 = at least one result was dropped.

Function
REQ-016 The block SHALL implement the states IDLE and ACC.
- IDLE -> ACC when en=1.
- ACC -> IDLE when en=0, discarding the partial window.
REQ-017 On the cycle that enters ACC, and on the cycle after each window completes, win_sel SHALL be latched; a change to win_sel mid-window SHALL take effect only from the next window.
REQ-018 In ACC, each cycle with sn_valid=1 SHALL increment the bit counter, and increment the ones counter when sn_bit=1.
- Cycles with sn_valid=0 SHALL change nothing.
REQ-019 The window SHALL complete on the cycle the Nth valid bit is accepted.
- Both counters restart at 0 from the next cycle.
- The next window starts back-to-back, with no gap cycle.
REQ-020 The result SHALL load into the output registers and out_valid SHALL rise one cycle after the completing bit; latency is 1 clock.
REQ-021 out_valid, ones_cnt, bipolar, unipolar_q8 and res_sel SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 A handshake SHALL occur when out_valid=1 and out_ready=1; out_valid falls on the next cycle unless a new result loads that same cycle.
REQ-023 If a result completes while the held result is being handshaken that same cycle, the new result SHALL load and out_valid SHALL stay 1; lost SHALL stay unchanged.
REQ-024 If a result completes while out_valid=1 and out_ready=0, the new result SHALL be dropped and lost SHALL be set.
REQ-025 unipolar_q8 SHALL equal ones_cnt shifted left by 8-log2(N); the value 256 (all ones with N=64) SHALL saturate to 255.
REQ-026 bipolar SHALL span -N..+N; with N=64 the range is -64..+64 and fits in 8 bits.
REQ-027 clear=1 SHALL do all of the following on the next cycle:
- zero both counters;
- drop out_valid;
- clear lost;
- keep the state (ACC stays ACC) and relatch win_sel.
REQ-028 Priority SHALL be rst_n > clear > en > normal operation.

Reset
REQ-029 While rst_n=1, the block SHALL set state=IDLE and zero both counters and the latched win_sel.
REQ-030 While rst_n=1, the block SHALL set out_valid=0, ones_cnt=0, bipolar=0, unipolar_q8=0, res_sel=0 and lost=0.
REQ-031 Reset asserted mid-window SHALL discard all partial and pending data with no output pulse.

Structure
REQ-032 Shared package sn_pkg SHALL hold:
- the state enum (IDLE, ACC);
- MIN_WIN_LOG2;
- a function from win_sel to N/log2N;
- the width constants for the counter (7) and the result (8).
REQ-033 One sub-module, sn_window_counter, SHALL contain the bit counter, the ones counter and the completion pulse.
- Result formatting and the valid/ready register stay in the top module.

Verification
REQ-034 win_sel=0, en=1, out_ready=1, sn_valid=1, pattern 10101010 -> one cycle after bit 8: out_valid=1, ones_cnt=4, bipolar=0, unipolar_q8=128.
REQ-035 win_sel=3, 64 ones -> ones_cnt=64, bipolar=+64, unipolar_q8=255 (saturated); 64 zeros -> ones_cnt=0, bipolar=-64 (0xC0), unipolar_q8=0.
REQ-036 win_sel=1, sn_valid toggling every other cycle, 16 valid ones -> result after 32 clocks, ones_cnt=16; the sn_bit=1 values presented with sn_valid=0 are not counted.
REQ-037 out_ready=0 across two completed 8-bit windows (ones 3 then 5) -> held result stays ones_cnt=3 and lost=1; clear=1 -> out_valid=0 and lost=0 next cycle.
REQ-038 Completion coincides with a handshake -> out_valid stays 1, the new value appears and lost=0.
REQ-039 win_sel changed 0->2 mid-window, then rst_n=1 pulsed mid-window -> the current window completes with N=8 and the next uses N=32; after the reset all outputs are 0 and there is no spurious out_valid.

Source files
------------

// File: rtl/sn_pkg.sv
// Shared types and constants for the stochastic stream decoder.
package sn_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   // log2 of the shortest window (N = 8 by default)
   localparam int unsigned MIN_WIN_LOG2 = 3;

   localparam int CNT_W = 7;   // ones / bit counter width (0..64)
   localparam int RES_W = 8;   // formatted result width
   localparam int LOG_W = 3;   // width of log2(N)

   // log2 of the window length selected by win_sel
   function automatic logic [LOG_W-1:0] win_log2(input int unsigned min_log2,
                                                 input logic [1:0] sel);
      return LOG_W'(min_log2) + LOG_W'(sel);
   endfunction

   // window length N from its log2
   function automatic logic [CNT_W-1:0] win_len(input logic [LOG_W-1:0] log2n);
      return CNT_W'(1) << log2n;
   endfunction

endpackage

// File: rtl/sn_stream_decoder_if.sv
// Stream-in / result-out bundle of the stochastic stream decoder.
//
// Handshake: the input stream has no backpressure; a bit is taken on every
// rising edge where sn_valid=1. On the result side a transfer happens on a
// rising edge where out_valid=1 and out_ready=1; while out_valid=1 and
// out_ready=0 the result fields are held stable and out_valid stays high.
interface sn_stream_decoder_if;
   import sn_pkg::*;

   logic             sn_bit;
   logic             sn_valid;
   logic             out_ready;
   logic             out_valid;
   logic [CNT_W-1:0] ones_cnt;
   logic [RES_W-1:0] bipolar;
   logic [RES_W-1:0] unipolar_q8;
   logic [1:0]       res_sel;
   logic             lost;

   // stimulus / consumer side
   modport master (
      output sn_bit, sn_valid, out_ready,
      input  out_valid, ones_cnt, bipolar, unipolar_q8, res_sel, lost
   );

   // decoder side
   modport slave (
      input  sn_bit, sn_valid, out_ready,
      output out_valid, ones_cnt, bipolar, unipolar_q8, res_sel, lost
   );

endinterface

// File: rtl/sn_window_counter.sv
// Counts valid bits and ones inside one window; pulses done on the Nth bit.
module sn_window_counter
   import sn_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             sn_bit,
   input  logic [LOG_W-1:0] n_log2,
   output logic             done,
   output logic [CNT_W-1:0] ones_total
);

   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] ones_cnt;
   logic [CNT_W-1:0] last_idx;

   assign last_idx   = win_len(n_log2) - CNT_W'(1);
   // ones count including the bit being accepted this cycle
   assign ones_total = ones_cnt + CNT_W'(sn_bit);
   assign done       = inc && (bit_cnt == last_idx);

   // counters: restart after the completing bit so windows run back-to-back
   always_ff @(posedge clk) begin
      if (rst || clr || done) begin
         bit_cnt  <= '0;
         ones_cnt <= '0;
      end else if (inc) begin
         bit_cnt  <= bit_cnt + CNT_W'(1);
         ones_cnt <= ones_total;
      end
   end

endmodule

// File: rtl/sn_stream_decoder.sv
// Decodes a stochastic bitstream into ones count, bipolar and unipolar values
// over windows of 8/16/32/64 bits, with a held valid/ready result register.
module sn_stream_decoder #(
   parameter int unsigned MIN_WIN_LOG2 = sn_pkg::MIN_WIN_LOG2
) (
   input  logic                clk,
   input  logic                rst_n,      // active-high despite the name
   input  logic                en,
   input  logic                clear,
   input  logic [1:0]          win_sel,
   sn_stream_decoder_if.slave  bus,
   output sn_pkg::state_t      state
);

   logic [1:0]                     win_lat;
   logic [sn_pkg::LOG_W-1:0]       n_log2;
   logic                           inc;
   logic                           cnt_clr;
   logic                           done;
   logic [sn_pkg::CNT_W-1:0]       ones_total;
   logic [8:0]                     uni_wide;
   logic [sn_pkg::RES_W-1:0]       uni_next;
   logic [sn_pkg::RES_W-1:0]       bip_next;

   assign n_log2  = sn_pkg::win_log2(MIN_WIN_LOG2, win_lat);
   assign inc     = (state == sn_pkg::ACC) && en && !clear && bus.sn_valid;
   // leaving ACC (en=0) or clear discards the partial window
   assign cnt_clr = clear || !en;

   sn_window_counter u_cnt (
      .clk        (clk),
      .rst        (rst_n),
      .clr        (cnt_clr),
      .inc        (inc),
      .sn_bit     (bus.sn_bit),
      .n_log2     (n_log2),
      .done       (done),
      .ones_total (ones_total)
   );

   // format the completing window: unipolar = ones*256/N (sat), bipolar = 2*ones-N
   always_comb begin
      uni_wide = 9'(ones_total) << (4'd8 - 4'(n_log2));
      uni_next = uni_wide[8] ? 8'hFF : uni_wide[7:0];
      bip_next = sn_pkg::RES_W'({ones_total, 1'b0}) - sn_pkg::RES_W'(sn_pkg::win_len(n_log2));
   end

   // control FSM: IDLE/ACC and window-length latch
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state   <= sn_pkg::IDLE;
         win_lat <= 2'd0;
      end else if (clear) begin
         win_lat <= win_sel;
      end else begin
         case (state)
            sn_pkg::IDLE: begin
               if (en) begin
                  state   <= sn_pkg::ACC;
                  win_lat <= win_sel;
               end
            end
            sn_pkg::ACC: begin
               if (!en) begin
                  state <= sn_pkg::IDLE;
               end else if (done) begin
                  win_lat <= win_sel;
               end
            end
            default: state <= sn_pkg::IDLE;
         endcase
      end
   end

   // result register: load on completion unless a held result is blocked
   always_ff @(posedge clk) begin
      if (rst_n) begin
         bus.out_valid   <= 1'b0;
         bus.ones_cnt    <= '0;
         bus.bipolar     <= '0;
         bus.unipolar_q8 <= '0;
         bus.res_sel     <= 2'd0;
         bus.lost        <= 1'b0;
      end else if (clear) begin
         bus.out_valid <= 1'b0;
         bus.lost      <= 1'b0;
      end else if (done) begin
         if (!bus.out_valid || bus.out_ready) begin
            bus.out_valid   <= 1'b1;
            bus.ones_cnt    <= ones_total;
            bus.bipolar     <= bip_next;
            bus.unipolar_q8 <= uni_next;
            bus.res_sel     <= win_lat;
         end else begin
            bus.lost <= 1'b1;
         end
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule
